// File: rtl/figure_pixel_generator_if.sv
// Scan-coordinate in / pattern-pixel out bundle between vga_sync, the figure source and the pixel sink.
interface figure_pixel_generator_if #(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 10,
    parameter int PIXEL_BITS  = 12
);
    logic [WIDTH_BITS-1:0]  pixel_x_in;
    logic [HEIGHT_BITS-1:0] pixel_y_in;
    logic                   video_on_in;
    logic                   pixel_bit_out;
    logic [PIXEL_BITS-1:0]  pixel_out;
    logic                   valid_out;

    modport master (
        output pixel_x_in, pixel_y_in, video_on_in,
        input  pixel_bit_out, pixel_out, valid_out
    );

    modport slave (
        input  pixel_x_in, pixel_y_in, video_on_in,
        output pixel_bit_out, pixel_out, valid_out
    );
endinterface

// File: rtl/figure_pixel_generator.sv
// Registered test-figure source: border | rectangle | circle mask for the current scan coordinate,
// one clock of latency, blanked outside the active region.
module figure_pixel_generator #(
    parameter int                    WIDTH       = 640,
    parameter int                    HEIGHT      = 480,
    parameter int                    WIDTH_BITS  = 10,
    parameter int                    HEIGHT_BITS = 10,
    parameter int                    PIXEL_BITS  = 12,
    parameter int                    BORDER      = 2,
    parameter int                    RECT_X0     = 100,
    parameter int                    RECT_X1     = 200,
    parameter int                    RECT_Y0     = 100,
    parameter int                    RECT_Y1     = 180,
    parameter int                    CIRC_CX     = 440,
    parameter int                    CIRC_CY     = 240,
    parameter int                    CIRC_R      = 60,
    parameter logic [PIXEL_BITS-1:0] FG_COLOR    = 12'hFFF,
    parameter logic [PIXEL_BITS-1:0] BG_COLOR    = 12'h000
) (
    input  logic                      clock_in,
    input  logic                      reset_in,
    figure_pixel_generator_if.slave   pix_if
);
    // Deltas need one sign bit over the coordinate width; the sum of squares one carry bit more.
    localparam int DW  = WIDTH_BITS + 1;
    localparam int SQW = 2 * DW + 1;

    localparam logic signed [DW-1:0] CX_S = DW'(CIRC_CX);
    localparam logic signed [DW-1:0] CY_S = DW'(CIRC_CY);
    localparam logic [SQW-1:0]       R_SQ = SQW'(CIRC_R * CIRC_R);

    logic                  pixel_bit_d, pixel_bit_q;
    logic [PIXEL_BITS-1:0] pixel_d, pixel_q;
    logic                  valid_d, valid_q;

    int                     x_i, y_i;
    logic                   in_range, border_hit, rect_hit, circ_hit;
    logic signed [DW-1:0]   dx, dy;
    logic signed [SQW-1:0]  dx_w, dy_w;
    logic [SQW-1:0]         dist_sq;

    always_comb begin
        x_i = int'(pixel_x_in_z());
        y_i = int'(pix_if.pixel_y_in);

        in_range   = (x_i < WIDTH) && (y_i < HEIGHT);
        border_hit = (x_i < BORDER) || (x_i >= WIDTH - BORDER) ||
                     (y_i < BORDER) || (y_i >= HEIGHT - BORDER);
        rect_hit   = (x_i >= RECT_X0) && (x_i < RECT_X1) &&
                     (y_i >= RECT_Y0) && (y_i < RECT_Y1);

        dx      = $signed(DW'(pix_if.pixel_x_in)) - CX_S;
        dy      = $signed(DW'(pix_if.pixel_y_in)) - CY_S;
        dx_w    = SQW'(dx);
        dy_w    = SQW'(dy);
        dist_sq = SQW'(dx_w * dx_w) + SQW'(dy_w * dy_w);
        circ_hit = (dist_sq <= R_SQ);

        // Out-of-range coordinates also suppress the border term, so blank them as a whole.
        pixel_bit_d = pix_if.video_on_in && in_range && (border_hit || rect_hit || circ_hit);
        pixel_d     = pixel_bit_d ? FG_COLOR : BG_COLOR;
        valid_d     = pix_if.video_on_in;
    end

    function automatic logic [WIDTH_BITS-1:0] pixel_x_in_z();
        return pix_if.pixel_x_in;
    endfunction

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            pixel_bit_q <= 1'b0;
            pixel_q     <= BG_COLOR;
            valid_q     <= 1'b0;
        end else begin
            pixel_bit_q <= pixel_bit_d;
            pixel_q     <= pixel_d;
            valid_q     <= valid_d;
        end
    end

    assign pix_if.pixel_bit_out = pixel_bit_q;
    assign pix_if.pixel_out     = pixel_q;
    assign pix_if.valid_out     = valid_q;

endmodule

// File: tb/tb_figure_pixel_generator.sv
// Randomized and directed check of figure_pixel_generator against a plain-arithmetic figure model.
module tb_figure_pixel_generator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    figure_pixel_generator_if #(.WIDTH_BITS(10), .HEIGHT_BITS(10), .PIXEL_BITS(12)) pix_if ();

    figure_pixel_generator dut (
        .clock_in (clk),
        .reset_in (rst),
        .pix_if   (pix_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the test figure as geometry on integer screen coordinates.
    function automatic bit model_mask(int x, int y);
        bit border, rect, circ;
        if (x >= 640 || y >= 480) return 1'b0;
        border = (x < 2) || (x > 637) || (y < 2) || (y > 477);
        rect   = (x >= 100) && (x <= 199) && (y >= 100) && (y <= 179);
        circ   = (x - 440) * (x - 440) + (y - 240) * (y - 240) <= 60 * 60;
        return border || rect || circ;
    endfunction

    // Apply one coordinate, clock it in, then compare the registered result.
    task automatic step(input string tag, input int x, input int y, input bit von, input bit r);
        bit m;
        pix_if.pixel_x_in  = x[9:0];
        pix_if.pixel_y_in  = y[9:0];
        pix_if.video_on_in = von;
        rst = r;
        @(posedge clk);
        #1;
        m = r ? 1'b0 : (von && model_mask(x, y));
        chk({tag, ".bit"},   32'(pix_if.pixel_bit_out), 32'(m));
        chk({tag, ".pix"},   32'(pix_if.pixel_out),     m ? 32'hFFF : 32'h000);
        chk({tag, ".valid"}, 32'(pix_if.valid_out),     r ? 32'd0 : 32'(von));
    endtask

    int dx_tab[17]  = '{0, 1, 639, 638, 2, 637, 100, 199, 200, 150, 440, 500, 501, 482, 483, 0, 700};
    int dy_tab[17]  = '{0, 240, 479, 10, 2, 477, 100, 179, 150, 180, 240, 240, 240, 282, 283, 0, 500};
    bit dv_tab[17]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    bit de_tab[17]  = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0};

    initial begin
        pix_if.pixel_x_in  = '0;
        pix_if.pixel_y_in  = '0;
        pix_if.video_on_in = 1'b0;
        @(posedge clk);
        #1;

        step("reset0", 0, 0, 1'b1, 1'b1);
        step("reset1", 440, 240, 1'b1, 1'b1);

        // Directed points; the table's expected column is cross-checked against the model too.
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("table%0d.model", i),
                32'(dv_tab[i] && model_mask(dx_tab[i], dy_tab[i])), 32'(de_tab[i]));
            step($sformatf("dir%0d", i), dx_tab[i], dy_tab[i], dv_tab[i], 1'b0);
        end

        // Sparse full-frame scan including horizontal/vertical blanking intervals.
        for (int y = 0; y < 525; y += 5) begin
            for (int x = 0; x < 800; x += 7) begin
                step("sweep", x, y, (x < 640) && (y < 480), 1'b0);
            end
        end

        // Dense rows across the circle centre with a mid-frame reset pulse at (320,240).
        for (int y = 238; y <= 242; y++) begin
            for (int x = 0; x < 640; x++) begin
                step("midrst", x, y, 1'b1, (x == 320) && (y == 240));
            end
        end

        // Random coordinates over the full counter range with random blanking and rare resets.
        for (int i = 0; i < 6000; i++) begin
            step("rand", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
